pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the datapath: the next-generation PC register. It keeps the existing multi-source next-PC select and write-enable behaviour and adds a configurable reset/trap vector, a hardware return-address stack (RAS) for call/return, and a one-level trap mechanism with a saved exception PC. It sits between the ALU/memory outputs and the instruction-fetch address, under control-unit command.

## Interface
- WIDTH, 16: PC and data width.
- RESET_VEC, 16'h0001: PC value loaded on reset.
- TRAP_VEC, 16'h0280: PC value loaded on trap entry and for unused `pc_src` codes.
- RAS_DEPTH, 4: return-address stack entries. Power of two, ≥2.

- clock  in  1  datapath clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-high reset.
- pcwr  in  1  PC write enable.
- pc_src  in  3  next-PC select.
- aluout  in  WIDTH  registered ALU result.
- alu  in  WIDTH  combinational ALU result.
- memout  in  WIDTH  memory read data.
- push  in  1  call: push current `pc` onto RAS. Qualified by `pcwr`.
- trap  in  1  trap/interrupt request, level-sampled.
- pc  out  WIDTH  program counter.
- epc  out  WIDTH  saved PC of the last trap entry.
- in_trap  out  1  trap handler active.
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries.
- ras_full / ras_empty  out  1 each  `ras_count==RAS_DEPTH` / `ras_count==0`.
- ras_ovf / ras_unf  out  1 each  sticky overflow / underflow flags.

## Operation
- **pc_src decode:**
  - 000: `aluout`
  - 001: `alu`
  - 011: `memout`
  - 100: RAS top (pop)
  - 101: `epc` (trap return)
  - 010, 110, 111: TRAP_VEC
- **State machine:** two states, RUN and TRAP. `in_trap` equals (state==TRAP).
- **Priority at each falling edge:** reset > trap entry > underflow trap > normal write.
- **Trap entry:** taken only when `trap`=1 and state=RUN, independent of `pcwr`.
  - `pc` ← TRAP_VEC, `epc` ← `pc`, state ← TRAP.
  - `push` and pops are suppressed that edge.
  - `trap` is ignored while in TRAP (no nesting). `epc` is held.
- **Normal write:** when `pcwr`=1, `pc` ← selected source.
  - `pc_src`=101 also sets state ← RUN. In RUN, 101 still loads `epc`.
  - When `pcwr`=0, `pc`, the RAS and the state are all held. `push` is ignored.
- **Push** (`pcwr`=1, `push`=1): writes the pre-update `pc` at the top. `ras_count` increments.
  - If full: the oldest entry is overwritten (circular), `ras_count` stays RAS_DEPTH, and `ras_ovf` ← 1.
- **Pop** (`pcwr`=1, `pc_src`=100, not empty): `pc` ← top, `ras_count` decrements.
- **Push with pop on the same edge:** `pc` ← old top, then the top entry is replaced by the pre-update `pc`. `ras_count` is unchanged and no flags change.
- **Pop when empty (underflow trap):**
  - `ras_unf` ← 1.
  - Behaves as a trap entry (`pc` ← TRAP_VEC, `epc` ← `pc`, state ← TRAP) if in RUN.
  - If already in TRAP: `pc` ← TRAP_VEC, `epc` held.
- **Pointer arithmetic:** modulo RAS_DEPTH. `ras_count` saturates at 0 and RAS_DEPTH.
- **Sticky flags:** `ras_ovf` and `ras_unf` clear only on reset.

## Timing
- **Reset** (asynchronous, immediate, no clock needed):
  - `pc`=RESET_VEC, `epc`=0, state=RUN, `in_trap`=0.
  - `ras_count`=0, `ras_empty`=1, `ras_full`=0, `ras_ovf`=0, `ras_unf`=0.
  - RAS contents are don't-care.
- **Reset deassertion:** the first update occurs at the next falling edge.
- **Reset mid-operation:** in-flight pushes, pops and traps are discarded.
- **Output timing:** all outputs are registered or decoded from registers only, with no combinational input→output path. `pc` changes one falling edge after the controls are sampled.
- **Input sampling:** inputs are sampled at the falling edge and must be stable around it. `trap` must be held until `in_trap` is observed.
- **Back-to-back:** a push followed by a pop on consecutive edges returns the pushed value. No bubble is required.

## Test plan
- **Reset:** assert reset between edges → `pc`=0x0001 and `ras_empty`=1 immediately. `pcwr`=1, `pc_src`=000, `aluout`=0x1234 → `pc`=0x1234 after the next falling edge. With `pcwr`=0 → `pc` held. Codes 010/110/111 → 0x0280.
- **Call/return:** `pc`=0x0010, push with `alu`=0x0200 → `pc`=0x0200, `ras_count`=1. Then pop → `pc`=0x0010, `ras_count`=0.
- **Overflow:** with RAS_DEPTH=4, push 5 times from pcs 0x10 to 0x14 → `ras_ovf`=1, `ras_count`=4. Four pops return 0x14, 0x13, 0x12, 0x11. A fifth pop → `pc`=0x0280, `ras_unf`=1, `in_trap`=1, `epc`=0x11.
- **Trap:** `pc`=0x0055, `trap`=1 with `pcwr`=0 → `pc`=0x0280, `epc`=0x0055, `in_trap`=1. A second `trap` → ignored. `pcwr`=1 with `pc_src`=101 → `pc`=0x0055, `in_trap`=0.
- **Push with pop on the same edge:** top=0x0030, `pc`=0x0040, push+pop → `pc`=0x0030, top=0x0040, count unchanged.
- **Trap vs write:** `trap`=1 with `pcwr`=1, `pc_src`=000, push=1 → trap wins, no RAS change. Reset asserted mid-trap → all reset values restored.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter register with multi-source next-PC select,
// a circular return-address stack and a one-level trap (RUN/TRAP) state.
// All state updates happen on the falling edge of clock; reset is
// asynchronous and active-high.
module pc_unit #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] RESET_VEC = 16'h0001,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 16'h0280,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         pcwr,
   input  logic [2:0]                   pc_src,
   input  logic [WIDTH-1:0]             aluout,
   input  logic [WIDTH-1:0]             alu,
   input  logic [WIDTH-1:0]             memout,
   input  logic                         push,
   input  logic                         trap,
   output logic [WIDTH-1:0]             pc,
   output logic [WIDTH-1:0]             epc,
   output logic                         in_trap,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_full,
   output logic                         ras_empty,
   output logic                         ras_ovf,
   output logic                         ras_unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

   state_t           state;
   logic [PW-1:0]    sp;           // next free slot; top of stack is sp-1
   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];

   logic [PW-1:0]    top_idx;
   logic             pop_req;
   logic             do_trap;
   logic             do_unf;
   logic             do_write;
   logic             do_push;
   logic             do_pop;
   logic             mem_we;
   logic [PW-1:0]    mem_waddr;
   logic [WIDTH-1:0] next_pc;

   // Status flags are decoded from registers only.
   assign in_trap   = (state == TRAP);
   assign ras_full  = (ras_count == CW'(RAS_DEPTH));
   assign ras_empty = (ras_count == '0);

   // Decode this edge's action in priority order: trap, underflow, write.
   always_comb begin
      top_idx   = sp - PW'(1);
      pop_req   = pcwr && (pc_src == 3'b100);
      do_trap   = trap && (state == RUN);
      do_unf    = !do_trap && pop_req && ras_empty;
      do_write  = !do_trap && !do_unf && pcwr;
      do_push   = do_write && push;
      do_pop    = do_write && pop_req;
      mem_we    = do_push;
      // A push paired with a pop replaces the entry just popped.
      mem_waddr = do_pop ? top_idx : sp;
   end

   // Next-PC source select; unused codes vector to the trap handler.
   always_comb begin
      next_pc = TRAP_VEC;
      case (pc_src)
         3'b000:  next_pc = aluout;
         3'b001:  next_pc = alu;
         3'b011:  next_pc = memout;
         3'b100:  next_pc = ras_mem[top_idx];
         3'b101:  next_pc = epc;
         default: next_pc = TRAP_VEC;
      endcase
   end

   // RAS storage: contents are don't-care after reset, so no reset here.
   always_ff @(negedge clock) begin
      if (!reset && mem_we) ras_mem[mem_waddr] <= pc;
   end

   // PC, EPC, RUN/TRAP state, stack pointer, count and sticky flags.
   always_ff @(negedge clock or posedge reset) begin
      if (reset) begin
         pc        <= RESET_VEC;
         epc       <= '0;
         state     <= RUN;
         sp        <= '0;
         ras_count <= '0;
         ras_ovf   <= 1'b0;
         ras_unf   <= 1'b0;
      end else if (do_trap) begin
         pc    <= TRAP_VEC;
         epc   <= pc;
         state <= TRAP;
      end else if (do_unf) begin
         ras_unf <= 1'b1;
         pc      <= TRAP_VEC;
         // Inside the handler the original exception PC is kept.
         if (state == RUN) begin
            epc   <= pc;
            state <= TRAP;
         end
      end else if (do_write) begin
         pc <= next_pc;
         if (pc_src == 3'b101) state <= RUN;
         case ({do_push, do_pop})
            2'b10: begin
               sp <= sp + PW'(1);
               // When full, sp already points at the oldest entry.
               if (ras_full) ras_ovf <= 1'b1;
               else          ras_count <= ras_count + CW'(1);
            end
            2'b01: begin
               sp        <= top_idx;
               ras_count <= ras_count - CW'(1);
            end
            default: ;  // none, or push+pop swap with unchanged depth
         endcase
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed, table-driven bench for pc_unit with hand-computed
// expectations, plus hand-written reset sequences.
module tb_pc_unit;

   logic        clock;
   logic        reset;
   logic        pcwr;
   logic [2:0]  pc_src;
   logic [15:0] aluout;
   logic [15:0] alu;
   logic [15:0] memout;
   logic        push;
   logic        trap;
   logic [15:0] pc;
   logic [15:0] epc;
   logic        in_trap;
   logic [2:0]  ras_count;
   logic        ras_full;
   logic        ras_empty;
   logic        ras_ovf;
   logic        ras_unf;

   int checks = 0;
   int errors = 0;

   pc_unit dut (
      .clock     (clock),
      .reset     (reset),
      .pcwr      (pcwr),
      .pc_src    (pc_src),
      .aluout    (aluout),
      .alu       (alu),
      .memout    (memout),
      .push      (push),
      .trap      (trap),
      .pc        (pc),
      .epc       (epc),
      .in_trap   (in_trap),
      .ras_count (ras_count),
      .ras_full  (ras_full),
      .ras_empty (ras_empty),
      .ras_ovf   (ras_ovf),
      .ras_unf   (ras_unf)
   );

   // Clock: falling edges at 5, 15, 25, ...
   initial begin
      clock = 1'b1;
      forever #5 clock = ~clock;
   end

   // Watchdog so the run always ends.
   initial begin
      #20000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic        pcwr;
      logic [2:0]  src;
      logic [15:0] aluout;
      logic [15:0] alu;
      logic [15:0] memout;
      logic        push;
      logic        trap;
      logic [15:0] e_pc;
      logic [15:0] e_epc;
      logic        e_trap;
      logic [2:0]  e_cnt;
      logic        e_ovf;
      logic        e_unf;
   } vec_t;

   vec_t tbl [64];
   int   n_vec = 0;

   task automatic add(input logic w, input logic [2:0] s, input logic [15:0] ao,
                      input logic [15:0] a, input logic [15:0] m, input logic p,
                      input logic t, input logic [15:0] ep, input logic [15:0] ee,
                      input logic et, input logic [2:0] ec, input logic eo,
                      input logic eu);
      tbl[n_vec] = '{w, s, ao, a, m, p, t, ep, ee, et, ec, eo, eu};
      n_vec++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [15:0] e_pc, input logic [15:0] e_epc,
                          input logic e_trap, input logic [2:0] e_cnt,
                          input logic e_ovf, input logic e_unf);
      chk({tag, ".pc"},        32'(pc),        32'(e_pc));
      chk({tag, ".epc"},       32'(epc),       32'(e_epc));
      chk({tag, ".in_trap"},   32'(in_trap),   32'(e_trap));
      chk({tag, ".ras_count"}, 32'(ras_count), 32'(e_cnt));
      chk({tag, ".ras_full"},  32'(ras_full),  32'(e_cnt == 3'd4));
      chk({tag, ".ras_empty"}, 32'(ras_empty), 32'(e_cnt == 3'd0));
      chk({tag, ".ras_ovf"},   32'(ras_ovf),   32'(e_ovf));
      chk({tag, ".ras_unf"},   32'(ras_unf),   32'(e_unf));
   endtask

   task automatic drive(input logic w, input logic [2:0] s, input logic [15:0] ao,
                        input logic [15:0] a, input logic [15:0] m,
                        input logic p, input logic t);
      pcwr = w; pc_src = s; aluout = ao; alu = a; memout = m; push = p; trap = t;
   endtask

   // Step past the next falling edge and sample 1 time unit later.
   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   initial begin
      // Sequential scenario; each row's expectation follows the previous row.
      //   pcwr src     aluout    alu       memout    push trap  pc        epc       trap cnt ovf unf
      add(1, 3'b000, 16'h1234, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
      add(0, 3'b000, 16'h5555, 16'h0000, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b010, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0280, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0abc, 16'h0000, 0, 0, 16'h0abc, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b110, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0280, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b011, 16'h0000, 16'h0000, 16'h0bcd, 0, 0, 16'h0bcd, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b111, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0280, 16'h0000, 0, 0, 0, 0);
      // call / return
      add(1, 3'b000, 16'h0010, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0200, 16'h0000, 1, 0, 16'h0200, 16'h0000, 0, 1, 0, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0010, 16'h0000, 0, 0, 0, 0);
      // overflow: push pcs 0x10..0x14
      add(1, 3'b001, 16'h0000, 16'h0011, 16'h0000, 1, 0, 16'h0011, 16'h0000, 0, 1, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0012, 16'h0000, 1, 0, 16'h0012, 16'h0000, 0, 2, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0013, 16'h0000, 1, 0, 16'h0013, 16'h0000, 0, 3, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0014, 16'h0000, 1, 0, 16'h0014, 16'h0000, 0, 4, 0, 0);
      add(1, 3'b001, 16'h0000, 16'h0015, 16'h0000, 1, 0, 16'h0015, 16'h0000, 0, 4, 1, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0014, 16'h0000, 0, 3, 1, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0013, 16'h0000, 0, 2, 1, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0012, 16'h0000, 0, 1, 1, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0011, 16'h0000, 0, 0, 1, 0);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0280, 16'h0011, 1, 0, 1, 1);
      add(1, 3'b101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0011, 16'h0011, 0, 0, 1, 1);
      // trap entry, ignored nested trap, trap return
      add(1, 3'b000, 16'h0055, 16'h0000, 16'h0000, 0, 0, 16'h0055, 16'h0011, 0, 0, 1, 1);
      add(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0280, 16'h0055, 1, 0, 1, 1);
      add(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0280, 16'h0055, 1, 0, 1, 1);
      add(1, 3'b101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0055, 16'h0055, 0, 0, 1, 1);
      // underflow while already in TRAP keeps epc
      add(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 1, 16'h0280, 16'h0055, 1, 0, 1, 1);
      add(1, 3'b000, 16'h0300, 16'h0000, 16'h0000, 0, 0, 16'h0300, 16'h0055, 1, 0, 1, 1);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0280, 16'h0055, 1, 0, 1, 1);
      add(1, 3'b101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0055, 16'h0055, 0, 0, 1, 1);
      // push with pop on the same edge
      add(1, 3'b000, 16'h0030, 16'h0000, 16'h0000, 0, 0, 16'h0030, 16'h0055, 0, 0, 1, 1);
      add(1, 3'b001, 16'h0000, 16'h0040, 16'h0000, 1, 0, 16'h0040, 16'h0055, 0, 1, 1, 1);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0030, 16'h0055, 0, 1, 1, 1);
      add(1, 3'b100, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0055, 0, 0, 1, 1);
      // trap beats a write with push
      add(1, 3'b000, 16'h9999, 16'h0000, 16'h0000, 1, 1, 16'h0280, 16'h0040, 1, 0, 1, 1);
      add(1, 3'b101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0040, 0, 0, 1, 1);
      // 101 in RUN still loads epc; pcwr=0 ignores push and pop
      add(1, 3'b000, 16'h0123, 16'h0000, 16'h0000, 0, 0, 16'h0123, 16'h0040, 0, 0, 1, 1);
      add(1, 3'b101, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0040, 16'h0040, 0, 0, 1, 1);
      add(0, 3'b100, 16'h0000, 16'h0000, 16'h0000, 1, 0, 16'h0040, 16'h0040, 0, 0, 1, 1);

      // Reset asserted from time 0, checked before any clock edge.
      reset = 1'b1;
      drive(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
      #2;
      chk_all("reset", 16'h0001, 16'h0000, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      chk("reset_release.pc", 32'(pc), 32'h0001);

      for (int i = 0; i < n_vec; i++) begin
         drive(tbl[i].pcwr, tbl[i].src, tbl[i].aluout, tbl[i].alu, tbl[i].memout,
               tbl[i].push, tbl[i].trap);
         tick();
         chk_all($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_epc, tbl[i].e_trap,
                 tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_unf);
      end

      // Reset mid-trap with a live RAS entry: everything returns to reset values.
      drive(1, 3'b001, 16'h0000, 16'h0777, 16'h0000, 1, 0);
      tick();
      chk("pre_rst.count", 32'(ras_count), 32'd1);
      drive(0, 3'b000, 16'h0000, 16'h0000, 16'h0000, 0, 1);
      tick();
      chk("pre_rst.in_trap", 32'(in_trap), 32'd1);
      chk("pre_rst.epc", 32'(epc), 32'h0777);
      #2;
      reset = 1'b1;
      #1;
      chk_all("mid_reset", 16'h0001, 16'h0000, 0, 0, 0, 0);
      drive(1, 3'b000, 16'h1234, 16'h0000, 16'h0000, 0, 0);
      tick();
      chk("held_in_reset.pc", 32'(pc), 32'h0001);
      reset = 1'b0;
      tick();
      chk("after_reset.pc", 32'(pc), 32'h1234);
      chk("after_reset.in_trap", 32'(in_trap), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
